// File: rtl/wb_region_xbar.sv
// -----------------------------------------------------------------------------
// wb_region_xbar
//   Single-master Wishbone (classic) to NUM_SLAVES region decoder.
//   A request is decoded against per-slave base/mask pairs; the lowest-index
//   hit wins. The slave select and the address, write data, selects and we are
//   registered, and the cycle is forwarded to exactly one slave. The ack and
//   read data come back to the master registered, one cycle after the slave
//   acks. Unmapped accesses, and slaves that do not ack within TIMEOUT cycles,
//   end with an m_err pulse carrying ERR_DATA.
//
// Ports
//   sys_clk, reset_n            clock, synchronous active-low reset
//   m_adr/m_dat_w/m_sel/m_we    master request attributes
//   m_cyc/m_stb                 master cycle and strobe
//   m_dat_r/m_ack/m_err         registered response to the master
//   s_adr/s_dat_w/s_sel/s_we    latched attributes, shared by all slaves
//   s_cyc/s_stb                 one-hot cycle/strobe per slave
//   s_dat_r/s_ack               packed slave read data, per-slave ack
//   err_adr                     address of the most recent errored access
// -----------------------------------------------------------------------------
module wb_region_xbar #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE =
    {32'h0000_0000, 32'h0320_0000, 32'h0340_0000, 32'h0330_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK =
    {32'h0000_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000},
  parameter int TIMEOUT    = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hBADC_0DE5
) (
  input  logic                         sys_clk,
  input  logic                         reset_n,
  input  logic [ADDR_W-1:0]            m_adr,
  input  logic [DATA_W-1:0]            m_dat_w,
  input  logic [DATA_W/8-1:0]          m_sel,
  input  logic                         m_we,
  input  logic                         m_cyc,
  input  logic                         m_stb,
  output logic [DATA_W-1:0]            m_dat_r,
  output logic                         m_ack,
  output logic                         m_err,
  output logic [ADDR_W-1:0]            s_adr,
  output logic [DATA_W-1:0]            s_dat_w,
  output logic [DATA_W/8-1:0]          s_sel,
  output logic                         s_we,
  output logic [NUM_SLAVES-1:0]        s_cyc,
  output logic [NUM_SLAVES-1:0]        s_stb,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_dat_r,
  input  logic [NUM_SLAVES-1:0]        s_ack,
  output logic [ADDR_W-1:0]            err_adr
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state;
  logic [IDX_W-1:0]  sel_idx;
  logic [CNT_W-1:0]  tmo_cnt;

  logic              dec_hit;
  logic [IDX_W-1:0]  dec_idx;
  logic [DATA_W-1:0] sel_dat;
  logic              sel_ack;

  // Scan from the top index down so the lowest-index hit is the one left.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((m_adr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
        dec_hit = 1'b1;
        dec_idx = IDX_W'(i);
      end
    end
  end

  // Only the strobed slave can complete the transfer; stray acks are masked.
  always_comb begin
    sel_dat = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_idx == IDX_W'(i)) sel_dat = s_dat_r[i*DATA_W +: DATA_W];
    end
    sel_ack = |(s_ack & s_stb);
  end

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      sel_idx <= '0;
      tmo_cnt <= '0;
      s_adr   <= '0;
      s_dat_w <= '0;
      s_sel   <= '0;
      s_we    <= 1'b0;
      s_cyc   <= '0;
      s_stb   <= '0;
      m_ack   <= 1'b0;
      m_err   <= 1'b0;
      m_dat_r <= '0;
      err_adr <= '0;
    end else begin
      // Responses are single-cycle pulses by default.
      m_ack <= 1'b0;
      m_err <= 1'b0;
      case (state)
        IDLE: begin
          if (m_cyc && m_stb) begin
            if (dec_hit) begin
              s_adr   <= m_adr;
              s_dat_w <= m_dat_w;
              s_sel   <= m_sel;
              s_we    <= m_we;
              sel_idx <= dec_idx;
              s_cyc   <= NUM_SLAVES'(1) << dec_idx;
              s_stb   <= NUM_SLAVES'(1) << dec_idx;
              tmo_cnt <= '0;
              state   <= BUSY;
            end else begin
              m_err   <= 1'b1;
              m_dat_r <= ERR_DATA;
              err_adr <= m_adr;
              state   <= RESP;
            end
          end
        end
        BUSY: begin
          // Ack beats abort and timeout when they coincide.
          if (sel_ack) begin
            m_ack   <= 1'b1;
            m_dat_r <= sel_dat;
            s_cyc   <= '0;
            s_stb   <= '0;
            state   <= RESP;
          end else if (!m_cyc) begin
            s_cyc   <= '0;
            s_stb   <= '0;
            state   <= IDLE;
          end else if ((TIMEOUT != 0) && (tmo_cnt == CNT_LAST)) begin
            m_err   <= 1'b1;
            m_dat_r <= ERR_DATA;
            err_adr <= s_adr;
            s_cyc   <= '0;
            s_stb   <= '0;
            state   <= RESP;
          end else if (tmo_cnt != CNT_MAX) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        // The master's strobe is ignored here; a follow-on request is decoded in IDLE.
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_region_xbar.sv
module tb_wb_region_xbar;

  localparam logic [31:0] ERR_DATA = 32'hBADC_0DE5;

  logic        sys_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] m_adr   = '0;
  logic [31:0] m_dat_w = '0;
  logic [3:0]  m_sel   = '0;
  logic        m_we    = 1'b0;
  logic        m_cyc   = 1'b0;
  logic        m_stb   = 1'b0;
  logic        use_b   = 1'b0;

  // DUT A: default map with catch-all slave 3, TIMEOUT 255.
  logic [31:0]  a_dat_r, a_s_adr, a_s_dat_w, a_err_adr;
  logic         a_ack, a_err, a_s_we;
  logic [3:0]   a_s_sel, a_s_cyc, a_s_stb, a_s_ack;
  logic [127:0] a_s_dat_r;
  // DUT B: no catch-all, TIMEOUT 4.
  logic [31:0]  b_dat_r, b_s_adr, b_s_dat_w, b_err_adr;
  logic         b_ack, b_err, b_s_we;
  logic [3:0]   b_s_sel, b_s_cyc, b_s_stb, b_s_ack;
  logic [127:0] b_s_dat_r;

  logic a_cyc, a_stb, b_cyc, b_stb;
  assign a_cyc = m_cyc & ~use_b;
  assign a_stb = m_stb & ~use_b;
  assign b_cyc = m_cyc & use_b;
  assign b_stb = m_stb & use_b;

  always #5 sys_clk = ~sys_clk;

  wb_region_xbar dut_a (
    .sys_clk(sys_clk), .reset_n(reset_n),
    .m_adr(m_adr), .m_dat_w(m_dat_w), .m_sel(m_sel), .m_we(m_we),
    .m_cyc(a_cyc), .m_stb(a_stb),
    .m_dat_r(a_dat_r), .m_ack(a_ack), .m_err(a_err),
    .s_adr(a_s_adr), .s_dat_w(a_s_dat_w), .s_sel(a_s_sel), .s_we(a_s_we),
    .s_cyc(a_s_cyc), .s_stb(a_s_stb), .s_dat_r(a_s_dat_r), .s_ack(a_s_ack),
    .err_adr(a_err_adr)
  );

  wb_region_xbar #(
    .SLV_BASE({32'h0700_0000, 32'h0320_0000, 32'h0340_0000, 32'h0330_0000}),
    .SLV_MASK({32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000}),
    .TIMEOUT(4)
  ) dut_b (
    .sys_clk(sys_clk), .reset_n(reset_n),
    .m_adr(m_adr), .m_dat_w(m_dat_w), .m_sel(m_sel), .m_we(m_we),
    .m_cyc(b_cyc), .m_stb(b_stb),
    .m_dat_r(b_dat_r), .m_ack(b_ack), .m_err(b_err),
    .s_adr(b_s_adr), .s_dat_w(b_s_dat_w), .s_sel(b_s_sel), .s_we(b_s_we),
    .s_cyc(b_s_cyc), .s_stb(b_s_stb), .s_dat_r(b_s_dat_r), .s_ack(b_s_ack),
    .err_adr(b_err_adr)
  );

  // Behavioural slaves: the strobed slave acks once its strobe has been
  // high for ack_wait cycles; noise acks hit only unstrobed slaves.
  logic [31:0] slave_data [4];
  int          ack_wait = 0;
  int          stb_cnt  = 0;
  logic        noise_en = 1'b0;
  logic [3:0]  noise    = '0;
  logic [3:0]  stb_mux;
  logic        resp_ok;

  assign stb_mux = use_b ? b_s_stb : a_s_stb;
  assign resp_ok = (stb_cnt >= ack_wait);

  always @(posedge sys_clk) stb_cnt <= (stb_mux != 0) ? stb_cnt + 1 : 0;
  always @(negedge sys_clk) noise <= 4'($urandom);

  always_comb begin
    a_s_ack = (a_s_stb & {4{resp_ok & ~use_b}}) | (noise & ~a_s_stb & {4{noise_en}});
    b_s_ack = (b_s_stb & {4{resp_ok & use_b}})  | (noise & ~b_s_stb & {4{noise_en}});
    for (int i = 0; i < 4; i++) begin
      a_s_dat_r[i*32 +: 32] = slave_data[i];
      b_s_dat_r[i*32 +: 32] = slave_data[i];
    end
  end

  // Observed signals of whichever DUT is under test.
  logic [31:0] o_dat_r, o_s_adr, o_s_dat_w, o_err_adr;
  logic        o_ack, o_err, o_s_we;
  logic [3:0]  o_s_sel, o_s_cyc, o_s_stb;
  always_comb begin
    o_dat_r   = use_b ? b_dat_r   : a_dat_r;
    o_s_adr   = use_b ? b_s_adr   : a_s_adr;
    o_s_dat_w = use_b ? b_s_dat_w : a_s_dat_w;
    o_err_adr = use_b ? b_err_adr : a_err_adr;
    o_ack     = use_b ? b_ack     : a_ack;
    o_err     = use_b ? b_err     : a_err;
    o_s_we    = use_b ? b_s_we    : a_s_we;
    o_s_sel   = use_b ? b_s_sel   : a_s_sel;
    o_s_cyc   = use_b ? b_s_cyc   : a_s_cyc;
    o_s_stb   = use_b ? b_s_stb   : a_s_stb;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Reference model: region rules and response timing from the map.
  logic [31:0] last_rdat [2];
  logic [31:0] last_err  [2];

  function automatic int model_decode(input logic b, input logic [31:0] adr);
    logic [31:0] base [4];
    logic [31:0] mask [4];
    base = '{32'h0330_0000, 32'h0340_0000, 32'h0320_0000, (b ? 32'h0700_0000 : 32'h0)};
    mask = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, (b ? 32'hFFFF_0000 : 32'h0)};
    for (int i = 0; i < 4; i++)
      if ((adr & mask[i]) == base[i]) return i;
    return -1;
  endfunction

  function automatic int model_timeout(input logic b);
    return b ? 4 : 255;
  endfunction

  // One master transfer, compared against the given expectations.
  task automatic xfer(input logic b, input logic [31:0] adr, input logic we,
                      input logic [31:0] dat, input logic [3:0] sel, input int wait_n,
                      input int exp_idx, input logic exp_err, input int exp_lat,
                      input logic [31:0] exp_rdat, input string name);
    int n, stb_cyc, attr_bad, onehot_bad, excl_bad, lat;
    logic done, got_ack, got_err;
    logic [31:0] rdat;
    logic [3:0] stb_or;
    n = 0; stb_cyc = 0; attr_bad = 0; onehot_bad = 0; excl_bad = 0; lat = 0;
    done = 1'b0; got_ack = 1'b0; got_err = 1'b0; rdat = '0; stb_or = '0;
    @(negedge sys_clk);
    use_b = b;
    #1;
    chk({name, "_hold_dat_r"}, o_dat_r, last_rdat[b]);
    m_adr = adr; m_we = we; m_dat_w = dat; m_sel = sel; ack_wait = wait_n;
    m_cyc = 1'b1; m_stb = 1'b1;
    while (!done && n < exp_lat + 10) begin
      @(posedge sys_clk); #1; n++;
      if (o_s_stb != 0) begin
        stb_or |= o_s_stb;
        stb_cyc++;
        if ($countones(o_s_stb) != 1) onehot_bad++;
        if (o_s_adr != adr || o_s_we != we || o_s_sel != sel || o_s_dat_w != dat ||
            o_s_cyc != o_s_stb) attr_bad++;
      end
      if (o_ack && o_err) excl_bad++;
      if (o_ack || o_err) begin
        done = 1'b1; got_ack = o_ack; got_err = o_err; rdat = o_dat_r; lat = n;
      end
    end
    m_cyc = 1'b0; m_stb = 1'b0;
    chk({name, "_responded"}, done, 1'b1);
    chk({name, "_kind"}, {got_ack, got_err}, {~exp_err, exp_err});
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_dat_r"}, rdat, exp_rdat);
    chk({name, "_stb_slaves"}, stb_or, (exp_idx < 0) ? 4'b0 : (4'b1 << exp_idx));
    chk({name, "_stb_cycles"}, stb_cyc, (exp_idx < 0) ? 0 : exp_lat - 1);
    chk({name, "_attr_onehot"}, {attr_bad[15:0], onehot_bad[15:0], excl_bad[15:0]}, 0);
    last_rdat[b] = exp_rdat;
    if (exp_err) last_err[b] = adr;
    chk({name, "_err_adr"}, o_err_adr, last_err[b]);
    @(posedge sys_clk); #1;
    chk({name, "_pulse_end"}, {o_ack, o_err, o_s_stb}, 0);
  endtask

  // Model-driven transfer used by the random phase.
  task automatic model_xfer(input logic b, input logic [31:0] adr, input logic we,
                            input logic [31:0] dat, input logic [3:0] sel, input int wait_n,
                            input string name);
    int idx, to;
    idx = model_decode(b, adr);
    to  = model_timeout(b);
    if (idx < 0)
      xfer(b, adr, we, dat, sel, wait_n, -1, 1'b1, 1, ERR_DATA, name);
    else if (to != 0 && wait_n >= to)
      xfer(b, adr, we, dat, sel, wait_n, idx, 1'b1, to + 1, ERR_DATA, name);
    else
      xfer(b, adr, we, dat, sel, wait_n, idx, 1'b0, wait_n + 2, slave_data[idx], name);
  endtask

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          wait_n;
    logic [31:0] sdat;
    int          exp_idx;
    int          exp_lat;
    logic [31:0] exp_rdat;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs [6];
    int bad, acks, c1, c2, n;
    logic [31:0] d1, d2, adr;
    // slave i returns sdat ^ (i * 32'h1111_1111)
    vecs[0] = '{32'h0330_0010, 1'b0, 32'h0,          4'hF, 0, 32'h1234_5678, 0, 2, 32'h1234_5678};
    vecs[1] = '{32'h0340_0044, 1'b1, 32'hA5A5_0001, 4'hF, 3, 32'hDEAD_0001, 1, 5, 32'hCFBC_1110};
    vecs[2] = '{32'h0320_FFFC, 1'b0, 32'h0,          4'h3, 1, 32'h0BAD_F00D, 2, 3, 32'h298F_D22F};
    vecs[3] = '{32'h0500_0000, 1'b0, 32'h0,          4'hF, 0, 32'h5555_AAAA, 3, 2, 32'h6666_9999};
    vecs[4] = '{32'h0330_FFFF, 1'b1, 32'h0F0F_F0F0, 4'h9, 2, 32'hCAFE_BABE, 0, 4, 32'hCAFE_BABE};
    vecs[5] = '{32'h0331_0000, 1'b0, 32'h0,          4'hF, 0, 32'h0000_0000, 3, 2, 32'h3333_3333};
    last_rdat = '{32'h0, 32'h0};
    last_err  = '{32'h0, 32'h0};
    for (int i = 0; i < 4; i++) slave_data[i] = '0;

    // Reset state
    repeat (3) @(posedge sys_clk);
    #1;
    chk("reset_a_outputs", |{a_dat_r, a_ack, a_err, a_s_adr, a_s_dat_w, a_s_sel, a_s_we,
                             a_s_cyc, a_s_stb, a_err_adr}, 1'b0);
    chk("reset_b_outputs", |{b_dat_r, b_ack, b_err, b_s_adr, b_s_dat_w, b_s_sel, b_s_we,
                             b_s_cyc, b_s_stb, b_err_adr}, 1'b0);
    reset_n = 1'b1;

    // Table-driven transfers on DUT A
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 4; i++) slave_data[i] = vecs[v].sdat ^ (32'h1111_1111 * i);
      xfer(1'b0, vecs[v].adr, vecs[v].we, vecs[v].dat, vecs[v].sel, vecs[v].wait_n,
           vecs[v].exp_idx, 1'b0, vecs[v].exp_lat, vecs[v].exp_rdat, $sformatf("vec%0d", v));
    end

    // Abort: master drops cyc while the slave is still waiting
    @(negedge sys_clk);
    use_b = 1'b0; m_adr = 32'h0340_0000; m_we = 1'b0; m_sel = 4'hF; ack_wait = 1000;
    m_cyc = 1'b1; m_stb = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("abort_stb_busy", a_s_stb, 4'b0010);
    m_cyc = 1'b0; m_stb = 1'b0;
    @(posedge sys_clk); #1;
    chk("abort_stb_cleared", {a_s_stb, a_s_cyc}, 8'h0);
    bad = 0;
    repeat (4) begin
      if (a_ack || a_err || a_s_stb != 0) bad++;
      @(posedge sys_clk); #1;
    end
    chk("abort_no_response", bad, 0);
    for (int i = 0; i < 4; i++) slave_data[i] = 32'h1234_5678 ^ (32'h1111_1111 * i);
    xfer(1'b0, 32'h0330_0010, 1'b0, 32'h0, 4'hF, 0, 0, 1'b0, 2, 32'h1234_5678, "after_abort");

    // DUT B: unmapped, timeout, and ack coinciding with the timeout
    for (int i = 0; i < 4; i++) slave_data[i] = 32'h4000_0000 + i;
    xfer(1'b1, 32'h0500_0000, 1'b0, 32'h0, 4'hF, 0, -1, 1'b1, 1, ERR_DATA, "unmapped");
    xfer(1'b1, 32'h0320_0000, 1'b0, 32'h0, 4'hF, 1000, 2, 1'b1, 5, ERR_DATA, "timeout");
    xfer(1'b1, 32'h0320_0010, 1'b0, 32'h0, 4'hF, 3, 2, 1'b0, 5, 32'h4000_0002, "ack_at_timeout");
    xfer(1'b1, 32'h0340_0020, 1'b1, 32'h1357_9BDF, 4'h6, 2, 1, 1'b0, 4, 32'h4000_0001, "ack_before_timeout");

    // Randomised transfers on both DUTs against the model
    noise_en = 1'b1;
    for (int t = 0; t < 240; t++) begin
      case ($urandom_range(0, 4))
        0: adr = {16'h0330, 16'($urandom)};
        1: adr = {16'h0340, 16'($urandom)};
        2: adr = {16'h0320, 16'($urandom)};
        3: adr = {16'h0700, 16'($urandom)};
        default: adr = $urandom;
      endcase
      for (int i = 0; i < 4; i++) slave_data[i] = $urandom;
      model_xfer(t[0], adr, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 6),
                 $sformatf("rnd%0d", t));
      repeat ($urandom_range(0, 2)) @(posedge sys_clk);
    end
    noise_en = 1'b0;

    // Reset while BUSY, with the slave acking in the reset cycle
    @(negedge sys_clk);
    use_b = 1'b0; slave_data[0] = 32'h7777_0000;
    m_adr = 32'h0330_0000; m_we = 1'b0; m_sel = 4'hF; ack_wait = 1;
    m_cyc = 1'b1; m_stb = 1'b1;
    @(posedge sys_clk); #1;
    chk("rst_busy_stb", a_s_stb, 4'b0001);
    @(posedge sys_clk); #1;
    chk("rst_slave_acking", a_s_ack[0], 1'b1);
    reset_n = 1'b0;
    @(posedge sys_clk); #1;
    chk("rst_outputs_zero", |{a_dat_r, a_ack, a_err, a_s_adr, a_s_dat_w, a_s_sel, a_s_we,
                              a_s_cyc, a_s_stb, a_err_adr, b_dat_r, b_err_adr}, 1'b0);
    m_cyc = 1'b0; m_stb = 1'b0;
    @(posedge sys_clk); #1;
    reset_n = 1'b1;
    bad = 0;
    repeat (3) begin
      @(posedge sys_clk); #1;
      if (a_ack || a_err || a_s_stb != 0) bad++;
    end
    chk("rst_no_ack", bad, 0);
    last_rdat = '{32'h0, 32'h0};
    last_err  = '{32'h0, 32'h0};

    // Back-to-back reads to slaves 0 and 1 with cyc held high
    @(negedge sys_clk);
    slave_data[0] = 32'h0A0A_0A0A; slave_data[1] = 32'h1B1B_1B1B;
    m_adr = 32'h0330_0004; m_we = 1'b0; m_sel = 4'hF; ack_wait = 0;
    m_cyc = 1'b1; m_stb = 1'b1;
    n = 0; acks = 0; c1 = 0; c2 = 0; d1 = '0; d2 = '0;
    while (acks < 2 && n < 40) begin
      @(posedge sys_clk); #1; n++;
      if (a_ack) begin
        acks++;
        if (acks == 1) begin
          c1 = n; d1 = a_dat_r; m_adr = 32'h0340_0008;
        end else begin
          c2 = n; d2 = a_dat_r;
        end
      end
    end
    m_cyc = 1'b0; m_stb = 1'b0;
    chk("b2b_ack_count", acks, 2);
    chk("b2b_first_latency", c1, 2);
    chk("b2b_spacing", c2 - c1, 3);
    chk("b2b_dat0", d1, 32'h0A0A_0A0A);
    chk("b2b_dat1", d2, 32'h1B1B_1B1B);
    @(posedge sys_clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
